// File: rtl/ifetch_ir.sv
// ----------------------------------------------------------------------------
// ifetch_ir -- instruction fetch / instruction register stage of the
// multi-cycle MIPS datapath.
//
// Holds the PC, issues one word read at a time to instruction memory over a
// req/ack handshake, latches the returned word into IR and presents it,
// split into its instruction fields, to decode. There is no prefetch: a new
// fetch starts only after decode consumes IR or a redirect arrives.
//
// Optional feature: define IFETCH_MISALIGN_EN to flag accepted redirects
// whose target has non-zero bits [1:0] (sticky misalign_err). Without the
// macro misalign_err is tied low and the low bits are silently cleared.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   imem_req, imem_addr     fetch request and word-aligned address
//   imem_ack, imem_rdata    one-cycle ack pulse with the instruction word
//   redirect_valid/_pc      branch/jump/exception redirect pulse and target
//   ir_ready                decode consumes IR this cycle
//   ir_valid, ir, ir_pc     live instruction, its word and its address
//   pc_plus4                ir_pc + 4 (link / branch base)
//   opcode..jaddr           combinational field slices of ir
//   misalign_err            sticky misaligned-redirect flag
// ----------------------------------------------------------------------------
module ifetch_ir #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ir_ready,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        VALID = 2'b10
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] ir_r, ir_s;
    logic [31:0] ir_pc_r, ir_pc_s;
    logic [31:0] pend_pc_r, pend_pc_s;
    logic        ir_valid_r, ir_valid_s;
    logic        squash_r, squash_s;
    logic        req_r, req_s;
    logic [31:0] redir_tgt_s;

    // Redirect targets are always used word-aligned.
    assign redir_tgt_s = redirect_pc & 32'hFFFF_FFFC;

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        ir_pc_s    = ir_pc_r;
        pend_pc_s  = pend_pc_r;
        ir_valid_s = ir_valid_r;
        squash_s   = squash_r;
        case (state_r)
            IDLE: begin
                state_s = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        // Redirect beats the returning data; any older
                        // pending redirect is superseded as well.
                        pc_s     = redir_tgt_s;
                        squash_s = 1'b0;
                    end else if (squash_r) begin
                        // Data belongs to a fetch overtaken by a redirect.
                        pc_s     = pend_pc_r;
                        squash_s = 1'b0;
                    end else begin
                        ir_s       = imem_rdata;
                        ir_pc_s    = pc_r;
                        pc_s       = pc_r + 32'd4;
                        ir_valid_s = 1'b1;
                        state_s    = VALID;
                    end
                end else begin
                    if (redirect_valid) begin
                        // Address must stay stable until ack, so park the
                        // target; the last redirect before ack wins.
                        squash_s  = 1'b1;
                        pend_pc_s = redir_tgt_s;
                    end else begin
                        squash_s  = squash_r;
                    end
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    ir_valid_s = 1'b0;
                    pc_s       = redir_tgt_s;
                    state_s    = FETCH;
                end else if (ir_ready) begin
                    // pc already equals ir_pc + 4.
                    ir_valid_s = 1'b0;
                    state_s    = FETCH;
                end else begin
                    state_s    = VALID;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        req_s = (state_s == FETCH);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            ir_r       <= 32'h0000_0000;
            ir_pc_r    <= 32'h0000_0000;
            pend_pc_r  <= 32'h0000_0000;
            ir_valid_r <= 1'b0;
            squash_r   <= 1'b0;
            req_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ir_r       <= ir_s;
            ir_pc_r    <= ir_pc_s;
            pend_pc_r  <= pend_pc_s;
            ir_valid_r <= ir_valid_s;
            squash_r   <= squash_s;
            req_r      <= req_s;
        end
    end

`ifdef IFETCH_MISALIGN_EN
    logic mis_r;
    logic mis_hit_s;

    // A redirect is accepted only in FETCH or VALID; IDLE ignores it.
    assign mis_hit_s = redirect_valid && (redirect_pc[1:0] != 2'b00) &&
                       ((state_r == FETCH) || (state_r == VALID));

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_r <= 1'b0;
        end else begin
            mis_r <= mis_r | mis_hit_s;
        end
    end

    assign misalign_err = mis_r;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem_req  = req_r;
    assign imem_addr = pc_r;
    assign ir_valid  = ir_valid_r;
    assign ir        = ir_r;
    assign ir_pc     = ir_pc_r;
    assign pc_plus4  = ir_pc_r + 32'd4;
    assign opcode    = ir_r[31:26];
    assign rs        = ir_r[25:21];
    assign rt        = ir_r[20:16];
    assign rd        = ir_r[15:11];
    assign shamt     = ir_r[10:6];
    assign funct     = ir_r[5:0];
    assign imm16     = ir_r[15:0];
    assign jaddr     = ir_r[25:0];

endmodule
